// File: rtl/clk_ratio_monitor_pkg.sv
// rtl/clk_ratio_monitor_pkg.sv - shared types, widths and helpers for the clock ratio monitor
//
// Purpose : FSM state encoding, count width and the saturating/absolute-difference
//           helpers used by the monitor datapath.
// Ports   : none (package).
package clk_ratio_monitor_pkg;

  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALIGN   = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_MAX) ? v : v + COUNT_W'(1);
  endfunction

  // Unsigned |a-b| with the subtraction ordered so it never underflows.
  function automatic logic [COUNT_W:0] abs_diff(input logic [COUNT_W:0] a,
                                                input logic [COUNT_W:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/clk_ratio_monitor_if.sv
// rtl/clk_ratio_monitor_if.sv - control/status bundle of the clock ratio monitor
//
// Purpose : groups the enable input and all status outputs of the monitor.
// Signals : enable_i       1 = monitor runs, 0 = idle with status cleared
//           locked_o       ratio good for the required number of windows
//           ref_lost_o     sticky reference-timeout flag
//           err_o          1-cycle pulse on a bad window or timeout
//           count_o        clk cycles in last completed window (saturating)
//           count_valid_o  1-cycle pulse when count_o updates
// Modports: master = monitor side, slave = consumer side.
interface clk_ratio_monitor_if;
  import clk_ratio_monitor_pkg::*;

  logic               enable_i;
  logic               locked_o;
  logic               ref_lost_o;
  logic               err_o;
  logic [COUNT_W-1:0] count_o;
  logic               count_valid_o;

  modport master (
    input  enable_i,
    output locked_o,
    output ref_lost_o,
    output err_o,
    output count_o,
    output count_valid_o
  );

  modport slave (
    output enable_i,
    input  locked_o,
    input  ref_lost_o,
    input  err_o,
    input  count_o,
    input  count_valid_o
  );

endinterface

// File: rtl/clk_ratio_monitor_edge_sync.sv
// rtl/clk_ratio_monitor_edge_sync.sv - reference clock synchroniser and rising-edge detector
//
// Purpose : brings the asynchronous reference into the clk_i domain through two
//           flops, delays it one more flop and flags the 0->1 transition.
// Ports   : clk_i   in  sampling clock
//           rst_ni  in  asynchronous active-low reset
//           d_i     in  asynchronous reference level
//           rise_o  out one-cycle pulse per synchronised rising edge
module clk_ratio_monitor_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  // [0],[1] form the synchroniser; [2] holds the previous synchronised level.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/clk_ratio_monitor.sv
// rtl/clk_ratio_monitor.sv - lock/health monitor for the generated clock against a reference
//
// Purpose : counts clk_i cycles across a window of reference rising edges, compares
//           the count against WINDOW_EDGES*EXP_RATIO and asserts locked after
//           LOCK_WINDOWS consecutive good windows; flags a lost reference.
// Ports   : clk_i     in  generated clock, sole clock domain
//           rst_ni    in  asynchronous active-low reset
//           clkref_i  in  reference clock, sampled as data
//           mon       if  control/status bundle (master modport)
module clk_ratio_monitor
  import clk_ratio_monitor_pkg::*;
#(
  parameter int WINDOW_EDGES   = 256,
  parameter int EXP_RATIO      = 4,
  parameter int TOLERANCE      = 2,
  parameter int LOCK_WINDOWS   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clkref_i,
  clk_ratio_monitor_if.master mon
);

  localparam int EDGE_W = (WINDOW_EDGES > 1) ? $clog2(WINDOW_EDGES) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

  localparam longint EXP_PROD = longint'(WINDOW_EDGES) * longint'(EXP_RATIO);
  // Expected count clamped into the 17-bit comparison space.
  localparam logic [COUNT_W:0] EXP_CNT =
    (EXP_PROD > 131071) ? '1 : (COUNT_W+1)'(EXP_PROD);
  // A saturated count can only be trusted when the target itself saturates.
  localparam bit EXP_SAT = (EXP_PROD >= 65535);
  localparam logic [COUNT_W:0] TOL = (COUNT_W+1)'(TOLERANCE);

  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(WINDOW_EDGES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_WINDOWS);

  logic ref_rise;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] cyc_q, cyc_d;
  logic [EDGE_W-1:0]  edge_q, edge_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               count_valid_q, count_valid_d;
  logic               err_q, err_d;
  logic               locked_q, locked_d;
  logic               ref_lost_q, ref_lost_d;

  logic [COUNT_W-1:0] cyc_inc;
  logic [COUNT_W:0]   win_diff;
  logic               win_good;
  logic               timeout_evt;

  clk_ratio_monitor_edge_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (clkref_i),
    .rise_o (ref_rise)
  );

  always_comb begin
    // Count of the window that would close this cycle (closing cycle included).
    cyc_inc     = sat_inc(cyc_q);
    win_diff    = abs_diff({1'b0, cyc_inc}, EXP_CNT);
    win_good    = (win_diff <= TOL) && ((cyc_inc != COUNT_MAX) || EXP_SAT);
    // Fires only on the cycle the idle counter reaches the limit, so the error
    // pulses once; a simultaneous reference edge wins.
    timeout_evt = !ref_rise && (idle_q == IDLE_LAST);

    state_d       = state_q;
    cyc_d         = cyc_q;
    edge_d        = edge_q;
    idle_d        = ref_rise ? '0 : ((idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_W'(1));
    good_d        = good_q;
    count_d       = count_q;
    count_valid_d = 1'b0;
    err_d         = 1'b0;
    locked_d      = 1'b0;
    ref_lost_d    = ref_lost_q;

    if ((state_q == ST_IDLE) || !mon.enable_i) begin
      // Disable wins over everything; an in-flight window is dropped and
      // count_o keeps the last completed value.
      state_d    = mon.enable_i ? ST_ALIGN : ST_IDLE;
      cyc_d      = '0;
      edge_d     = '0;
      idle_d     = '0;
      good_d     = '0;
      ref_lost_d = 1'b0;
    end else if (timeout_evt) begin
      state_d    = ST_ALIGN;
      good_d     = '0;
      ref_lost_d = 1'b1;
      err_d      = 1'b1;
    end else begin
      // Registered from good_q so locked follows the qualifying count_valid by a cycle.
      locked_d = (good_q == GOOD_MAX);
      if (ref_rise) begin
        ref_lost_d = 1'b0;
      end
      case (state_q)
        ST_ALIGN: begin
          if (ref_rise) begin
            state_d = ST_MEASURE;
            cyc_d   = '0;
            edge_d  = '0;
          end
        end
        ST_MEASURE: begin
          cyc_d = cyc_inc;
          if (ref_rise) begin
            if (edge_q == EDGE_LAST) begin
              // Closing edge also opens the next window with no gap.
              count_d       = cyc_inc;
              count_valid_d = 1'b1;
              cyc_d         = '0;
              edge_d        = '0;
              if (win_good) begin
                good_d = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);
              end else begin
                good_d = '0;
                err_d  = 1'b1;
              end
            end else begin
              edge_d = edge_q + EDGE_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cyc_q         <= '0;
      edge_q        <= '0;
      idle_q        <= '0;
      good_q        <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      err_q         <= 1'b0;
      locked_q      <= 1'b0;
      ref_lost_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      edge_q        <= edge_d;
      idle_q        <= idle_d;
      good_q        <= good_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      err_q         <= err_d;
      locked_q      <= locked_d;
      ref_lost_q    <= ref_lost_d;
    end
  end

  assign mon.locked_o      = locked_q;
  assign mon.ref_lost_o    = ref_lost_q;
  assign mon.err_o         = err_q;
  assign mon.count_o       = count_q;
  assign mon.count_valid_o = count_valid_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb/tb_clk_ratio_monitor.sv - scoreboard bench for the clock ratio monitor
module tb_clk_ratio_monitor;
  import clk_ratio_monitor_pkg::*;

  typedef struct {
    logic [15:0] count;
    logic        bad;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clkref;

  clk_ratio_monitor_if mon_if ();

  clk_ratio_monitor dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clkref_i (clkref),
    .mon      (mon_if)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int   cyc = 0;
  int   cv_total = 0;
  int   last_cv_cyc = 0;
  int   err_total = 0;
  int   lock_cv = -1;
  int   lock_gap = -1;
  int   reflost_cyc = -1;
  int   last_rise_cyc = 0;
  logic reflost_locked = 1'b0;
  logic locked_prev = 1'b0;
  logic ref_lost_prev = 1'b0;

  int   ref_period = 4;
  bit   ref_run = 1'b0;
  int   stretch_amt = 0;
  int   stretch_tag = 0;

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int n, input logic [15:0] c, input logic bad);
    exp_t e;
    e.count = c;
    e.bad   = bad;
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic wait_cv(input string tag, input int target);
    int k;
    int budget;
    k = 0;
    budget = (target - cv_total) * 1400 + 400;
    while (cv_total < target && k < budget) begin
      sample();
      k++;
    end
    check_eq(tag, 32'(cv_total >= target), 1);
  endtask

  task automatic check_lock(input int cv_at);
    repeat (3) sample();
    check_eq("lock_after_cv_index", lock_cv, cv_at);
    check_eq("lock_gap_cycles", lock_gap, 1);
    check_eq("locked_level", mon_if.locked_o, 1);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_if.count_valid_o) begin
        cv_total++;
        last_cv_cyc = cyc;
        check_eq("sb_has_entry", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("count", mon_if.count_o, e.count);
          check_eq("err_at_cv", mon_if.err_o, e.bad);
        end
      end
      if (mon_if.err_o) err_total++;
      if (mon_if.locked_o && !locked_prev) begin
        lock_cv  = cv_total;
        lock_gap = cyc - last_cv_cyc;
      end
      if (mon_if.ref_lost_o && !ref_lost_prev) begin
        reflost_cyc    = cyc;
        reflost_locked = mon_if.locked_o;
      end
      locked_prev   = mon_if.locked_o;
      ref_lost_prev = mon_if.ref_lost_o;
    end
  endtask

  // Reference generator: high for period/2 clk cycles, low for the rest plus
  // any one-shot stretch requested by the driver.
  initial begin : ref_gen
    int seen;
    int lo;
    seen   = 0;
    clkref = 1'b0;
    forever begin
      if (ref_run) begin
        clkref        = 1'b1;
        last_rise_cyc = cyc;
        repeat (ref_period / 2) step();
        clkref = 1'b0;
        lo     = ref_period - ref_period / 2;
        if (stretch_tag != seen) begin
          lo  += stretch_amt;
          seen = stretch_tag;
        end
        repeat (lo) step();
      end else begin
        step();
      end
    end
  end

  initial begin : driver
    int snap_err;
    int snap_cv;
    int k;
    fork
      monitor_loop();
    join_none

    rst_n           = 1'b0;
    mon_if.enable_i = 1'b0;
    repeat (3) step();
    sample();
    check_eq("rst_locked", mon_if.locked_o, 0);
    check_eq("rst_ref_lost", mon_if.ref_lost_o, 0);
    check_eq("rst_err", mon_if.err_o, 0);
    check_eq("rst_count", mon_if.count_o, 0);
    check_eq("rst_count_valid", mon_if.count_valid_o, 0);

    // Nominal 4:1 ratio, lock after four windows.
    ref_period = 4;
    ref_run    = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    snap_err        = err_total;
    lock_cv         = -1;
    mon_if.enable_i = 1'b1;
    push(4, 16'd1024, 1'b0);
    wait_cv("s1_windows", 4);
    check_lock(4);
    check_eq("s1_no_err", err_total - snap_err, 0);

    // Tolerance boundary: +2 stays good, +3 is bad and drops lock.
    push(1, 16'd1026, 1'b0);
    stretch_amt = 2;
    stretch_tag++;
    wait_cv("s3_tol_good", 5);
    check_eq("s3_locked_after_good", mon_if.locked_o, 1);
    push(1, 16'd1027, 1'b1);
    stretch_amt = 3;
    stretch_tag++;
    wait_cv("s3_tol_bad", 6);
    check_eq("s3_locked_at_bad_cv", mon_if.locked_o, 1);
    sample();
    check_eq("s3_locked_dropped", mon_if.locked_o, 0);

    // Relock, then lose the reference.
    lock_cv = -1;
    push(4, 16'd1024, 1'b0);
    wait_cv("s4_relock1", 10);
    check_lock(10);
    snap_err = err_total;
    snap_cv  = cv_total;
    step();
    ref_run     = 1'b0;
    reflost_cyc = -1;
    k = 0;
    while (!mon_if.ref_lost_o && k < 400) begin
      sample();
      k++;
    end
    check_eq("s4_ref_lost_set", mon_if.ref_lost_o, 1);
    check_eq("s4_ref_lost_timing", reflost_cyc - last_rise_cyc, 67);
    check_eq("s4_locked_at_lost", reflost_locked, 0);
    repeat (100) sample();
    check_eq("s4_ref_lost_sticky", mon_if.ref_lost_o, 1);
    check_eq("s4_single_err", err_total - snap_err, 1);
    check_eq("s4_no_cv", cv_total - snap_cv, 0);
    check_eq("s4_unlocked", mon_if.locked_o, 0);
    step();
    ref_run = 1'b1;
    lock_cv = -1;
    push(4, 16'd1024, 1'b0);
    repeat (12) sample();
    check_eq("s4_ref_lost_cleared", mon_if.ref_lost_o, 0);
    wait_cv("s4_relock2", 14);
    check_lock(14);

    // Reset mid-window while locked.
    repeat (300) sample();
    step();
    rst_n = 1'b0;
    #1;
    check_eq("s6_rst_locked", mon_if.locked_o, 0);
    check_eq("s6_rst_count", mon_if.count_o, 0);
    check_eq("s6_rst_ref_lost", mon_if.ref_lost_o, 0);
    check_eq("s6_rst_err", mon_if.err_o, 0);
    check_eq("s6_rst_count_valid", mon_if.count_valid_o, 0);
    repeat (3) step();
    rst_n   = 1'b1;
    lock_cv = -1;
    push(4, 16'd1024, 1'b0);
    wait_cv("s6_relock", 18);
    check_lock(18);

    // Disable mid-window: idle next cycle, window discarded.
    repeat (300) sample();
    snap_cv  = cv_total;
    snap_err = err_total;
    step();
    mon_if.enable_i = 1'b0;
    @(posedge clk);
    sample();
    check_eq("s5_locked_off", mon_if.locked_o, 0);
    check_eq("s5_count_kept", mon_if.count_o, 1024);
    repeat (1500) sample();
    check_eq("s5_no_cv", cv_total - snap_cv, 0);
    check_eq("s5_count_still", mon_if.count_o, 1024);
    check_eq("s5_no_err", err_total - snap_err, 0);
    step();
    mon_if.enable_i = 1'b1;
    push(1, 16'd1024, 1'b0);
    wait_cv("s5_reenable", 19);
    check_eq("s5_not_locked_yet", mon_if.locked_o, 0);

    // Wrong ratio: 5 clk per reference period.
    step();
    mon_if.enable_i = 1'b0;
    ref_period      = 5;
    repeat (30) step();
    snap_err        = err_total;
    mon_if.enable_i = 1'b1;
    push(2, 16'd1280, 1'b1);
    wait_cv("s2_windows", 21);
    repeat (2) sample();
    check_eq("s2_locked_low", mon_if.locked_o, 0);
    check_eq("s2_err_per_window", err_total - snap_err, 2);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
